// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } sb_state_e;

   // Smallest r with 2**r >= n; used to size the ring pointers.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search of a load address against the buffered store addresses.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup with no handshake.
module sb_fwd_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   localparam int PW   = clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]         valid_i,
   input  logic [DEPTH-1:0][AW-1:0] addr_i,
   input  logic [PW-1:0]            wr_ptr_i,
   input  logic [AW-1:0]            ld_addr_i,
   output logic                     hit_o,
   output logic [PW-1:0]            idx_o
);

   logic [PW-1:0] pos;

   // Walk from oldest slot (wr_ptr-DEPTH) to youngest (wr_ptr-1); the last match seen wins.
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      pos   = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         pos = wr_ptr_i - PW'(k);
         if (valid_i[pos] && (addr_i[pos] == ld_addr_i)) begin
            hit_o = 1'b1;
            idx_o = pos;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the memory stage and data memory; STORE_BUFFER_FWD_EN enables load forwarding.
// Latency: mem_req rises one cycle after the first entry lands; back-to-back drains at one entry per cycle.
// Backpressure: full stalls the pipeline (stores while full are dropped and flag err_ovf); drain waits on mem_ack.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW,
   localparam int PW   = clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          DM_WE,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   output logic          full,
   output logic          empty,
   output logic          err_ovf,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hit,
   output logic [DW-1:0] ld_data
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   sb_state_e               state_q, state_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    err_ovf_q, err_ovf_d;
   logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
   logic [DEPTH-1:0][DW-1:0] data_q, data_d;

   logic push;
   logic pop;

   // Status is decoded from registered count so no input reaches full/empty combinationally.
   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign err_ovf = err_ovf_q;
   assign mem_req = (state_q == BUSY);

   // A same-cycle ack never frees space for a push: full comes from count_q.
   assign push = DM_WE & ~full;
   assign pop  = mem_req & mem_ack;

   // Head entry is presented only while requesting; it cannot change until acked.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if (mem_req) begin
         mem_addr  = addr_q[rd_ptr_q];
         mem_wdata = data_q[rd_ptr_q];
      end
   end

   // Pointer, occupancy, storage and sticky overflow next-state.
   always_comb begin
      wr_ptr_d  = wr_ptr_q + PW'(push);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      count_d   = count_q + CW'(push) - CW'(pop);
      err_ovf_d = err_ovf_q | (DM_WE & full);
      addr_d    = addr_q;
      data_d    = data_q;
      if (push) begin
         addr_d[wr_ptr_q] = st_addr;
         data_d[wr_ptr_q] = st_data;
      end
   end

   // Drain FSM: start one cycle after occupancy is seen, stop when the last entry is acked.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (count_q != '0) state_d = BUSY;
         BUSY:    if (pop && (count_d == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset drops any queued entries, including one mid-request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_ovf_q <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_ovf_q <= err_ovf_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

`ifdef STORE_BUFFER_FWD_EN
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    off;
   logic             fwd_hit;
   logic [PW-1:0]    fwd_idx;

   // Slot i is live if its distance from the head is below count; the entry being popped stays live this cycle.
   always_comb begin
      valid = '0;
      off   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off      = PW'(i) - rd_ptr_q;
         valid[i] = ({1'b0, off} < count_q);
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fwd_match (
      .valid_i   (valid),
      .addr_i    (addr_q),
      .wr_ptr_i  (wr_ptr_q),
      .ld_addr_i (ld_addr),
      .hit_o     (fwd_hit),
      .idx_o     (fwd_idx)
   );

   assign ld_hit  = fwd_hit;
   assign ld_data = fwd_hit ? data_q[fwd_idx] : '0;
`else
   // Without forwarding the pipeline holds loads until empty; the lookup port is left idle.
   logic unused_ld_addr;
   assign unused_ld_addr = ^ld_addr;
   assign ld_hit  = 1'b0;
   assign ld_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, AW=DW=32).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic        clk;
   logic        reset;
   logic        DM_WE;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        full;
   logic        empty;
   logic        err_ovf;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;

   int n_tests;
   int n_fail;

   store_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .DM_WE     (DM_WE),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .full      (full),
      .empty     (empty),
      .err_ovf   (err_ovf),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .ld_addr   (ld_addr),
      .ld_hit    (ld_hit),
      .ld_data   (ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      DM_WE   = 1'b1;
      st_addr = a;
      st_data = d;
      tick();
      DM_WE   = 1'b0;
   endtask

   logic        exp_fwd_hit;
   logic [31:0] exp_fwd_data;
   logic [31:0] wa [0:5];
   logic [31:0] wd [0:5];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      DM_WE   = 1'b0;
      st_addr = '0;
      st_data = '0;
      mem_ack = 1'b0;
      ld_addr = '0;
      for (int i = 0; i < 6; i++) begin
         wa[i] = 32'h200 + 32'(i * 4);
         wd[i] = 32'hA0 + 32'(i);
      end

      // Reset state
      #12;
      chk("rst_full",    64'(full),      64'd0);
      chk("rst_empty",   64'(empty),     64'd1);
      chk("rst_err_ovf", 64'(err_ovf),   64'd0);
      chk("rst_mem_req", 64'(mem_req),   64'd0);
      chk("rst_addr",    64'(mem_addr),  64'd0);
      chk("rst_wdata",   64'(mem_wdata), 64'd0);
      chk("rst_ld_hit",  64'(ld_hit),    64'd0);
      chk("rst_ld_data", 64'(ld_data),   64'd0);
      reset = 1'b1;
      tick();

      // Single store with two cycles of ack delay
      store(32'h10, 32'hAA);
      chk("s1_not_empty", 64'(empty),   64'd0);
      chk("s1_req_early", 64'(mem_req), 64'd0);
      tick();
      chk("s1_req",   64'(mem_req),   64'd1);
      chk("s1_addr",  64'(mem_addr),  64'h10);
      chk("s1_wdata", 64'(mem_wdata), 64'hAA);
      tick();
      chk("s1_hold1", 64'(mem_addr),  64'h10);
      tick();
      chk("s1_hold2", 64'(mem_wdata), 64'hAA);
      chk("s1_req2",  64'(mem_req),   64'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("s1_empty", 64'(empty),        64'd1);
      chk("s1_idle",  64'(mem_req),      64'd0);
      chk("s1_state", 64'(dut.state_q),  64'(IDLE));

      // Fill to DEPTH and overflow
      for (int i = 0; i < 4; i++) begin
         chk("fill_not_full", 64'(full), 64'd0);
         store(32'(i * 4), 32'h100 + 32'(i));
      end
      chk("fill_full",    64'(full),    64'd1);
      chk("fill_no_ovf",  64'(err_ovf), 64'd0);
      store(32'h20, 32'h1FF);
      chk("ovf_flag",     64'(err_ovf),     64'd1);
      chk("ovf_full",     64'(full),        64'd1);
      chk("ovf_count",    64'(dut.count_q), 64'd4);
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_req",   64'(mem_req),   64'd1);
         chk("drain_addr",  64'(mem_addr),  64'(i * 4));
         chk("drain_wdata", 64'(mem_wdata), 64'h100 + 64'(i));
         tick();
      end
      mem_ack = 1'b0;
      chk("drain_empty",  64'(empty),   64'd1);
      chk("drain_idle",   64'(mem_req), 64'd0);
      chk("ovf_sticky",   64'(err_ovf), 64'd1);

      // Wrap-around with push and pop coinciding at count 1
      store(wa[0], wd[0]);
      tick();
      chk("wrap_req", 64'(mem_req), 64'd1);
      for (int k = 1; k < 6; k++) begin
         DM_WE   = 1'b1;
         st_addr = wa[k];
         st_data = wd[k];
         mem_ack = 1'b1;
         chk("wrap_head_addr", 64'(mem_addr),  64'(wa[k-1]));
         chk("wrap_head_data", 64'(mem_wdata), 64'(wd[k-1]));
         tick();
         chk("wrap_count", 64'(dut.count_q), 64'd1);
         chk("wrap_req_on", 64'(mem_req),    64'd1);
      end
      DM_WE = 1'b0;
      chk("wrap_last_addr", 64'(mem_addr), 64'(wa[5]));
      tick();
      mem_ack = 1'b0;
      chk("wrap_empty", 64'(empty),   64'd1);
      chk("wrap_idle",  64'(mem_req), 64'd0);

      // Forwarding lookups
`ifdef STORE_BUFFER_FWD_EN
      exp_fwd_hit  = 1'b1;
      exp_fwd_data = 32'h22;
`else
      exp_fwd_hit  = 1'b0;
      exp_fwd_data = 32'h0;
`endif
      store(32'h40, 32'h11);
      store(32'h40, 32'h22);
      ld_addr = 32'h40;
      #1;
      chk("fwd40_hit",  64'(ld_hit),  64'(exp_fwd_hit));
      chk("fwd40_data", 64'(ld_data), 64'(exp_fwd_data));
      ld_addr = 32'h44;
      #1;
      chk("fwd44_hit",  64'(ld_hit),  64'd0);
      chk("fwd44_data", 64'(ld_data), 64'd0);
      DM_WE   = 1'b1;
      st_addr = 32'h44;
      st_data = 32'h33;
      #1;
      chk("fwd_same_cycle", 64'(ld_hit), 64'd0);
      tick();
      DM_WE = 1'b0;
      #1;
`ifdef STORE_BUFFER_FWD_EN
      exp_fwd_data = 32'h33;
`endif
      chk("fwd44b_hit",  64'(ld_hit),  64'(exp_fwd_hit));
      chk("fwd44b_data", 64'(ld_data), 64'(exp_fwd_data));

      // Asynchronous reset while draining three entries
      chk("mid_req",   64'(mem_req), 64'd1);
      chk("mid_count", 64'(dut.count_q), 64'd3);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_req",   64'(mem_req), 64'd0);
      chk("arst_empty", 64'(empty),   64'd1);
      chk("arst_ovf",   64'(err_ovf), 64'd0);
      chk("arst_hit",   64'(ld_hit),  64'd0);
      #1;
      reset = 1'b1;
      tick();
      store(32'h80, 32'h55);
      chk("post_not_empty", 64'(empty), 64'd0);
      tick();
      chk("post_req",   64'(mem_req),   64'd1);
      chk("post_addr",  64'(mem_addr),  64'h80);
      chk("post_wdata", 64'(mem_wdata), 64'h55);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("post_empty", 64'(empty), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Receiving end of the data-memory write-enable path: captures every cycle where `DM_WE` = 1, together with the store address and data, into an in-order FIFO.
- Drains entries to data memory over a req/ack handshake.
- Sits between the execute/memory pipeline stage and the data memory.
- Raises `full` so the pipeline stalls.
- Optionally forwards buffered store data to younger loads.

Parameters:
- DEPTH, 4, number of entries (power of 2, >= 2)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- DM_WE  in  1  store enable from the control unit
- st_addr  in  AW  store address, sampled when `DM_WE` = 1
- st_data  in  DW  store data, sampled when `DM_WE` = 1
- full  out  1  count == DEPTH; the pipeline must stall stores while this is high
- empty  out  1  count == 0
- err_ovf  out  1  sticky; set when a store arrives while `full` = 1
- mem_req  out  1  drain request to data memory
- mem_addr  out  AW  head entry address, valid while `mem_req` = 1
- mem_wdata  out  DW  head entry data, valid while `mem_req` = 1
- mem_ack  in  1  memory accepted the head entry this cycle
- ld_addr  in  AW  load address for the forwarding lookup
- ld_hit  out  1  a buffered store matches `ld_addr`
- ld_data  out  DW  data of the youngest matching store

Behaviour:
- Reset (reset = 0, asynchronous):
  - `wr_ptr` = `rd_ptr` = 0, count = 0, FSM = IDLE.
  - `full` = 0, `empty` = 1, `err_ovf` = 0, `mem_req` = 0.
  - `mem_addr`/`mem_wdata` = 0, `ld_hit` = 0, `ld_data` = 0.
  - Reset mid-drain discards all entries; the memory side must ignore a dropped request.
- Storage: circular array of DEPTH entries.
  - Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
  - count is log2(DEPTH)+1 bits wide.
- Push:
  - `DM_WE` = 1 and `full` = 0: write {`st_addr`, `st_data`} at `wr_ptr`, then increment `wr_ptr`.
  - `DM_WE` = 1 and `full` = 1: store dropped, no state change, `err_ovf` set (cleared only by reset).
  - A same-cycle `mem_ack` does not make room; `full` is evaluated on registered count.
- Drain FSM, states IDLE and BUSY:
  - IDLE: `mem_req` = 0. Move to BUSY on the next edge when count != 0, so a push into an empty buffer raises `mem_req` one cycle later.
  - BUSY: `mem_req` = 1; `mem_addr`/`mem_wdata` = entry[`rd_ptr`], held stable until `mem_ack`.
  - On `mem_ack` in BUSY: pop (`rd_ptr`++). Stay in BUSY if the post-update count != 0, else go to IDLE.
  - Back-to-back drains run at one entry per cycle while acks are continuous.
- `mem_ack` while in IDLE is ignored.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
  - With count = 1, the pushed entry becomes the new head.
- Forwarding:
  - Combinational compare of `ld_addr` against all valid entries (full-width address match).
  - The youngest valid match (closest to `wr_ptr`-1) wins.
  - The entry currently being popped still counts as valid this cycle.
  - A same-cycle incoming store is not forwarded.
- Outputs `full`/`empty` are decoded from registered count only (no input-to-output paths).

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined: `ld_hit`/`ld_data` behave as described above.
- Undefined:
  - The compare logic is not built; `ld_hit` = 0 and `ld_data` = 0 constantly.
  - The pipeline must stall loads until `empty` = 1.
- Ports are present in both builds.

Decomposition:
- Package `store_buffer_pkg`:
  - FSM state typedef (IDLE = 0, BUSY = 1).
  - Default DEPTH/AW/DW constants.
  - Pointer-width function clog2.
- One natural sub-module, `sb_fwd_match`:
  - Takes the valid vector, address array, age order (`wr_ptr`) and `ld_addr`.
  - Returns hit and index.
  - Instantiated only under STORE_BUFFER_FWD_EN.

Test Plan:
- Single store, fixed ack delay:
  - Stimulus: reset released; `DM_WE` = 1 for one cycle with addr 0x10, data 0xAA; `mem_ack` held 0 for 2 cycles, then pulsed.
  - Response: `mem_req` rises 1 cycle after the push with `mem_addr` = 0x10, `mem_wdata` = 0xAA stable; `empty` = 1 after the ack; FSM returns to IDLE.
- Fill and overflow (DEPTH = 4):
  - Stimulus: 4 consecutive stores to 0x0, 0x4, 0x8, 0xC with no ack, then a 5th store to 0x20.
  - Response: `full` = 1 after the 4th store; 5th store dropped and `err_ovf` = 1; draining with continuous ack emits 0x0, 0x4, 0x8, 0xC on 4 consecutive cycles.
- Wrap-around and simultaneous push/pop:
  - Stimulus: 6 stores interleaved with acks such that push and ack coincide with count = 1.
  - Response: count stays 1; FIFO order preserved across the pointer wrap.
- Forwarding (macro on):
  - Stimulus: stores (0x40, 0x11) then (0x40, 0x22); `ld_addr` = 0x40, then `ld_addr` = 0x44.
  - Response: for 0x40, `ld_hit` = 1 and `ld_data` = 0x22; for 0x44, `ld_hit` = 0.
  - Macro off, same stimulus: `ld_hit` = 0 throughout.
- Reset mid-drain:
  - Stimulus: 3 entries queued with `mem_req` = 1; assert reset asynchronously between clock edges.
  - Response: immediately `mem_req` = 0, `empty` = 1, `err_ovf` = 0; after release, the buffer accepts a fresh store normally.
